// File: rtl/imm_gen_if.sv
// Valid/ready bus for imm_gen_pipe: the instruction beat on the input side, the immediate beat on the output side.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_out;
  logic [TAG_W-1:0] out_tag;
  logic             imm_err;

  // Producer/consumer side; it drives beats in and accepts results.
  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, imm_out, out_tag, imm_err
  );

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, imm_out, out_tag, imm_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with a registered output and a one-entry skid buffer.
// Define IMM_GEN_ZICSR_EN to decode imm_src 101 as the CSR zimm format; otherwise 101 is reserved.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  imm_gen_if.slave bus
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] SRC_Z = 3'b101;
`endif

  // Every format is built as a 32-bit signed value; widening to XLEN is a pure sign extension.
  function automatic logic signed [31:0] decode32(input logic [31:0] ins,
                                                  input logic [2:0]  src,
                                                  output logic       err);
    logic s;
    s   = ins[31];
    err = 1'b0;
    case (src)
      SRC_I:   decode32 = {{20{s}}, ins[31:20]};
      SRC_S:   decode32 = {{20{s}}, ins[31:25], ins[11:7]};
      SRC_B:   decode32 = {{19{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SRC_U:   decode32 = {ins[31:12], 12'b0};
      SRC_J:   decode32 = {{11{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
      SRC_Z:   decode32 = {27'b0, ins[19:15]};
`endif
      default: begin
        decode32 = '0;
        err      = 1'b1;
      end
    endcase
  endfunction

  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    sext_xlen = XLEN'(v);
  endfunction

  // Stage p0: combinational decode of the offered beat
  logic signed [31:0]      raw_p0;
  logic signed [XLEN-1:0]  imm_p0;
  logic                    err_p0;
  logic                    unused_opcode;

  always_comb begin
    err_p0 = 1'b0;
    raw_p0 = decode32(bus.instr, bus.imm_src, err_p0);
    imm_p0 = sext_xlen(raw_p0);
  end

  assign unused_opcode = ^bus.instr[6:0];

  // Stage p1: output register plus skid register
  logic                    vld_p1;
  logic signed [XLEN-1:0]  imm_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic                    err_p1;
  logic                    skid_vld_p1;
  logic signed [XLEN-1:0]  skid_imm_p1;
  logic [TAG_W-1:0]        skid_tag_p1;
  logic                    skid_err_p1;

  logic accept;
  logic drain;

  assign accept = bus.in_valid && !skid_vld_p1;
  assign drain  = vld_p1 && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      imm_p1      <= '0;
      tag_p1      <= '0;
      err_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      skid_imm_p1 <= '0;
      skid_tag_p1 <= '0;
      skid_err_p1 <= 1'b0;
    end else if (drain && skid_vld_p1) begin
      // in_ready is low whenever the skid is full, so no new beat competes here
      imm_p1      <= skid_imm_p1;
      tag_p1      <= skid_tag_p1;
      err_p1      <= skid_err_p1;
      skid_vld_p1 <= 1'b0;
    end else if (accept && (!vld_p1 || drain)) begin
      vld_p1 <= 1'b1;
      imm_p1 <= imm_p0;
      tag_p1 <= bus.in_tag;
      err_p1 <= err_p0;
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
      skid_imm_p1 <= imm_p0;
      skid_tag_p1 <= bus.in_tag;
      skid_err_p1 <= err_p0;
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = !skid_vld_p1;
  assign bus.out_valid = vld_p1;
  assign bus.imm_out   = imm_p1;
  assign bus.out_tag   = tag_p1;
  assign bus.imm_err   = err_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and streaming checks of imm_gen_pipe, with XLEN=32 and XLEN=64 instances driven in parallel.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(32)) if32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(32)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.instr     = instr;
  assign if32.imm_src   = imm_src;
  assign if32.in_tag    = in_tag;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.instr     = instr;
  assign if64.imm_src   = imm_src;
  assign if64.in_tag    = in_tag;
  assign if64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] tag;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode by arithmetic shifts on a sign-extended 64-bit copy of the word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          output logic err);
    longint x;
    x   = longint'($signed(ins));
    err = 1'b0;
    case (src)
      3'd0: ref_imm = x >>> 20;
      3'd1: ref_imm = ((x >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: ref_imm = ((x >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                    | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: ref_imm = x & ~64'hFFF;
      3'd4: ref_imm = ((x >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                    | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
`ifdef IMM_GEN_ZICSR_EN
      3'd5: ref_imm = longint'(ins[19:15]);
`endif
      default: begin
        ref_imm = '0;
        err     = 1'b1;
      end
    endcase
  endfunction

  function automatic logic [31:0] bp_instr(input logic [31:0] t);
    logic [11:0] f;
    f = t[11:0];
    return {f, 20'h00093};
  endfunction

  task automatic chk_out(input string nm, input logic [31:0] tag, input logic [31:0] e32,
                         input logic [63:0] e64, input logic err);
    chk({nm, ".vld32"}, 64'(if32.out_valid), 64'd1);
    chk({nm, ".imm32"}, 64'(if32.imm_out), 64'(e32));
    chk({nm, ".tag32"}, 64'(if32.out_tag), 64'(tag));
    chk({nm, ".err32"}, 64'(if32.imm_err), 64'(err));
    chk({nm, ".vld64"}, 64'(if64.out_valid), 64'd1);
    chk({nm, ".imm64"}, if64.imm_out, e64);
    chk({nm, ".tag64"}, 64'(if64.out_tag), 64'(tag));
    chk({nm, ".err64"}, 64'(if64.imm_err), 64'(err));
  endtask

  initial begin
    logic [63:0] e;
    logic        eerr;
    logic [31:0] held_imm;

    vecs[0]  = '{32'hFFF00093, 3'd0, 32'h1000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE20AE23, 3'd1, 32'h1004, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 3'd2, 32'h1008, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h123450B7, 3'd3, 32'h100C, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{32'h0080006F, 3'd4, 32'h1010, 32'h00000008, 64'h0000000000000008, 1'b0};
    vecs[5]  = '{32'h800000B7, 3'd3, 32'h1014, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
`ifdef IMM_GEN_ZICSR_EN
    vecs[6]  = '{32'h000F9073, 3'd5, 32'h1018, 32'h0000001F, 64'h000000000000001F, 1'b0};
`else
    vecs[6]  = '{32'h000F9073, 3'd5, 32'h1018, 32'h00000000, 64'h0000000000000000, 1'b1};
`endif
    vecs[7]  = '{32'h000F9073, 3'd7, 32'h101C, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[8]  = '{32'hFFF00093, 3'd6, 32'h1020, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[9]  = '{32'h7FF00093, 3'd0, 32'h1024, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[10] = '{32'hFFFFF06F, 3'd4, 32'h1028, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vecs[11] = '{32'h00000463, 3'd2, 32'h102C, 32'h00000008, 64'h0000000000000008, 1'b0};

    // Reset state
    #12;
    chk("rst.vld", 64'(if32.out_valid), 64'd0);
    chk("rst.imm", if64.imm_out, 64'd0);
    chk("rst.tag", 64'(if32.out_tag), 64'd0);
    chk("rst.err", 64'(if32.imm_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst.rdy", 64'(if32.in_ready), 64'd1);

    // Table vectors, back-to-back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      imm_src  = vecs[i].src;
      in_tag   = vecs[i].tag;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].tag, vecs[i].exp32, vecs[i].exp64, vecs[i].err);
    end
    in_valid = 1'b0;
    step();
    chk("idle.vld", 64'(if32.out_valid), 64'd0);

    // Backpressure: fill output and skid, hold tag 3 at the producer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_src   = 3'd0;
    in_tag    = 32'd1;
    instr     = bp_instr(32'd1);
    step();
    chk("bp.t1", 64'(if32.out_tag), 64'd1);
    chk("bp.rdy1", 64'(if32.in_ready), 64'd1);
    held_imm = if32.imm_out;
    in_tag   = 32'd2;
    instr    = bp_instr(32'd2);
    step();
    chk("bp.rdy2", 64'(if32.in_ready), 64'd0);
    in_tag = 32'd3;
    instr  = bp_instr(32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp.hold_vld", 64'(if32.out_valid), 64'd1);
      chk("bp.hold_tag", 64'(if32.out_tag), 64'd1);
      chk("bp.hold_imm", 64'(if32.imm_out), 64'(held_imm));
      chk("bp.hold_rdy", 64'(if32.in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk_out("bp.o2", 32'd2, 32'd2, 64'd2, 1'b0);
    chk("bp.rdy_rec", 64'(if32.in_ready), 64'd1);
    step();
    chk_out("bp.o3", 32'd3, 32'd3, 64'd3, 1'b0);
    in_valid = 1'b0;
    step();
    chk("bp.empty", 64'(if32.out_valid), 64'd0);

    // Streaming: random beats, one per cycle
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      instr    = $urandom;
      imm_src  = 3'($urandom_range(0, 7));
      in_tag   = 32'(i) + 32'h2000;
      e        = ref_imm(instr, imm_src, eerr);
      step();
      chk_out($sformatf("stream%0d", i), in_tag, e[31:0], e, eerr);
      chk("stream.rdy", 64'(if32.in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Asynchronous reset with both registers full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_src   = 3'd0;
    in_tag    = 32'h55;
    instr     = bp_instr(32'h55);
    step();
    in_tag = 32'h66;
    instr  = bp_instr(32'h66);
    step();
    chk("mid.full", 64'(if32.in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid.vld32", 64'(if32.out_valid), 64'd0);
    chk("mid.vld64", 64'(if64.out_valid), 64'd0);
    chk("mid.imm", if64.imm_out, 64'd0);
    chk("mid.tag", 64'(if32.out_tag), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mid.rdy", 64'(if32.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid.nostale", 64'(if32.out_valid | if64.out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Extracts and sign-extends every RV32I/RV64I immediate format (I, S, B, U, J) from a 32-bit instruction into an XLEN-bit immediate. A valid/ready skid buffer gives it a registered output, full throughput and correct backpressure. It sits between fetch/decode and the register-read stage, and carries a sideband tag (normally the PC) aligned with each immediate.

## Interface
- XLEN, 32: immediate width; 32 or 64 only.
- TAG_W, 32: sideband tag width, passed through unmodified.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- instr  in  32  instruction word.
- imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 reserved.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- imm_out  out  XLEN  generated immediate.
- out_tag  out  TAG_W  tag aligned with imm_out.
- imm_err  out  1  set when imm_src was reserved (or 101 with Z disabled).

## Operation
- Formats, with s = instr[31] replicated to fill XLEN:
  - I: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {s, instr[31:12], 12'b0}. For XLEN=64, bits 63:32 are copies of bit 31.
  - J: {s, instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extended instr[19:15].
  - Error case: imm_out = 0, imm_err = 1.
- Decode is combinational from instr/imm_src. The result is registered into the output stage.
- Storage: output register (out_valid, imm_out, out_tag, imm_err) plus one skid register of the same contents.
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- Input accepted (in_valid && in_ready):
  - If the output stage is empty, or it is draining this cycle (out_ready) with the skid empty, the beat loads the output stage.
  - Otherwise it loads the skid.
- Output drained (out_valid && out_ready) with the skid full: the skid moves to the output stage and skid_valid clears. A new beat accepted in the same cycle is impossible, because in_ready = 0.
- Drained with no replacement: out_valid clears.
- out_valid never drops, and output contents never change, while out_valid && !out_ready.
- Beats leave in order, with no loss or duplication.

## Timing
- Latency: one cycle from acceptance to out_valid when the output stage is free.
- Throughput: one beat per cycle while out_ready is held high.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid = 0, skid_valid = 0, in_ready = 1 (from the first clk edge after rst deasserts).
  - imm_out = 0, out_tag = 0, imm_err = 0.
  - In-flight beats are discarded.
- Simultaneous accept and drain with the skid empty: the output stage is replaced and out_valid stays 1.
- Full condition: both registers valid, so in_ready = 0. It recovers the cycle after a drain.
- Ready/valid protocol: the producer must hold in_valid/instr stable until accepted. The block does not sample while in_ready = 0.

## Configuration
- IMM_GEN_ZICSR_EN:
  - Defined: imm_src 101 produces the Z format with imm_err = 0.
  - Undefined: 101 is treated as reserved (imm_out = 0, imm_err = 1) and no Z logic is synthesised.

## Test plan
- I/S/B, XLEN=32, out_ready = 1:
  - 0xFFF00093 I → 0xFFFFFFFF.
  - 0xFE20AE23 S → 0xFFFFFFFC.
  - 0xFE000EE3 B → 0xFFFFFFFC.
  - Each appears one cycle after acceptance, tags matching.
- U/J, XLEN=64:
  - 0x123450B7 U → 0x0000000012345000.
  - 0x0080006F J → 0x0000000000000008.
  - 0x800000B7 U → 0xFFFFFFFF80000000.
- Z and reserved, instr 0x000F9073 (rs1 field 31):
  - With the macro, imm_src 101 → 0x1F, imm_err 0.
  - Without the macro → 0, imm_err 1.
  - imm_src 111 → 0, imm_err 1, in both builds.
- Backpressure:
  - Hold out_ready = 0 and offer tags 1, 2, 3 back-to-back.
  - in_ready drops after the second acceptance, and tag 3 is held by the producer.
  - Release out_ready: outputs 1, 2, 3 in order on consecutive cycles, with imm_out stable throughout the stall.
- Streaming: 100 random beats with out_ready = 1 give one output per cycle, in order, matching the reference decode.
- Reset mid-operation:
  - Assert rst with both registers full: out_valid goes to 0 immediately (asynchronously) and in_ready = 1 after release.
  - No stale beat is emitted afterwards.
